// File: rtl/lca_pkg.sv
// lca_pkg: shared FSM state type and default geometry for the wide-add sequencer
package lca_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int LCA_WIDTH = 4;
  localparam int LCA_CHUNKS = 4;
endpackage

// File: rtl/lca.sv
// lca: WIDTH-bit adder slice with carry in and carry out
module lca #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic [WIDTH-1:0] s,
  output logic             co
);
  assign {co, s} = {1'b0, a} + {1'b0, b} + (WIDTH + 1)'(ci);
endmodule

// File: rtl/lca_seq.sv
// lca_seq: TOTAL-bit adder that reuses one WIDTH-bit lca slice over CHUNKS cycles, LSB chunk first
module lca_seq
  import lca_pkg::*;
#(
  parameter int WIDTH  = LCA_WIDTH,
  parameter int CHUNKS = LCA_CHUNKS
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH*CHUNKS-1:0]   a,
  input  logic [WIDTH*CHUNKS-1:0]   b,
  input  logic                      ci,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH*CHUNKS-1:0]   s,
  output logic                      co,
  output logic                      busy
);
  localparam int TOTAL = WIDTH * CHUNKS;
  localparam int IW = CHUNKS > 1 ? $clog2(CHUNKS) : 1;
  localparam logic [IW-1:0] LAST = IW'(CHUNKS - 1);
  state_t state;
  logic [TOTAL-1:0] a_q, b_q;
  logic carry_q;
  logic [IW-1:0] idx;
  logic [WIDTH-1:0] sl_s;
  logic sl_co;
  lca #(.WIDTH(WIDTH)) u_lca (
    .a  (a_q[idx*WIDTH +: WIDTH]),
    .b  (b_q[idx*WIDTH +: WIDTH]),
    .ci (carry_q),
    .s  (sl_s),
    .co (sl_co)
  );
  // in_ready/out_valid/busy are registered alongside state so no input reaches them combinationally
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      carry_q   <= 1'b0;
      idx       <= '0;
      s         <= '0;
      co        <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            a_q      <= a;
            b_q      <= b;
            carry_q  <= ci;
            idx      <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          s[idx*WIDTH +: WIDTH] <= sl_s;
          carry_q <= sl_co;
          if (idx == LAST) begin
            co        <= sl_co;
            out_valid <= 1'b1;
            state     <= DONE;
          end else
            idx <= idx + 1'b1;
        end
        DONE:
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_lca_seq.sv
// tb_lca_seq: randomized and directed checks of lca_seq against a plain a+b+ci reference
module tb_lca_seq;
  localparam int W = 4;
  localparam int C = 4;
  localparam int T = W * C;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic in_valid = 1'b0, out_ready = 1'b0, ci = 1'b0;
  logic [T-1:0] a = '0, b = '0;
  logic in_ready, out_valid, co, busy;
  logic [T-1:0] s;
  logic in_valid1 = 1'b0, out_ready1 = 1'b0, ci1 = 1'b0;
  logic [W-1:0] a1 = '0, b1 = '0;
  logic in_ready1, out_valid1, co1, busy1;
  logic [W-1:0] s1;
  int n_cmp = 0;
  int n_bad = 0;

  lca_seq #(.WIDTH(W), .CHUNKS(C)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .ci(ci), .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .co(co), .busy(busy)
  );

  lca_seq #(.WIDTH(W), .CHUNKS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .ci(ci1), .out_valid(out_valid1), .out_ready(out_ready1),
    .s(s1), .co(co1), .busy(busy1)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // stay=1 keeps in_valid high with a fresh request during RUN/DONE, which must be ignored
  task automatic run_add(input logic [T-1:0] ta, input logic [T-1:0] tb, input logic tci,
                         input int hold, input logic stay);
    int t;
    logic [T:0] e;
    e = {1'b0, ta} + {1'b0, tb} + (T + 1)'(tci);
    t = 0;
    while (!in_ready && t < 50) begin
      tick();
      t++;
    end
    check("in_ready_wait", in_ready, 1);
    in_valid = 1'b1;
    a = ta;
    b = tb;
    ci = tci;
    tick();
    in_valid = stay;
    a = stay ? 16'hAAAA : 16'($urandom);
    b = stay ? 16'h5555 : 16'($urandom);
    ci = stay ? 1'b0 : 1'($urandom);
    t = 0;
    while (!out_valid && t < 20) begin
      check("busy_in_ready", in_ready, 0);
      tick();
      t++;
    end
    check("latency", t, C);
    check("sum", s, e[T-1:0]);
    check("carry_out", co, e[T]);
    check("busy", busy, 1);
    out_ready = 1'b0;
    repeat (hold) begin
      tick();
      check("hold_valid", out_valid, 1);
      check("hold_in_ready", in_ready, 0);
      check("hold_sum", s, e[T-1:0]);
      check("hold_co", co, e[T]);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("idle_valid", out_valid, 0);
    check("idle_in_ready", in_ready, 1);
    check("sum_kept", s, e[T-1:0]);
  endtask

  initial begin
    logic [W:0] e1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_sum", s, 0);
    check("rst_co", co, 0);
    check("rst_in_ready1", in_ready1, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("release_in_ready", in_ready, 1);
    check("release_in_ready1", in_ready1, 1);

    run_add(16'h1234, 16'h4321, 1'b0, 0, 1'b0);
    run_add(16'hFFFF, 16'h0000, 1'b1, 0, 1'b0);
    run_add(16'h8000, 16'h8000, 1'b0, 10, 1'b0);
    run_add(16'h0001, 16'h0001, 1'b0, 2, 1'b1);
    run_add(16'hAAAA, 16'h5555, 1'b0, 0, 1'b0);

    // reset while idx == 2: two RUN edges after acceptance
    in_valid = 1'b1;
    a = 16'hFFFF;
    b = 16'hFFFF;
    ci = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("async_in_ready", in_ready, 0);
    check("async_out_valid", out_valid, 0);
    check("async_busy", busy, 0);
    check("async_sum", s, 0);
    check("async_co", co, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("rerelease_in_ready", in_ready, 1);
    repeat (C + 2) begin
      tick();
      check("discarded_valid", out_valid, 0);
    end

    for (int i = 0; i < 40; i++)
      run_add(16'($urandom), 16'($urandom), 1'($urandom), int'($urandom_range(0, 3)), 1'b0);

    for (int i = 0; i < 9; i++) begin
      a1 = (i == 0) ? 4'hF : 4'($urandom);
      b1 = (i == 0) ? 4'h1 : 4'($urandom);
      ci1 = (i == 0) ? 1'b0 : 1'($urandom);
      e1 = {1'b0, a1} + {1'b0, b1} + 5'(ci1);
      check("c1_in_ready", in_ready1, 1);
      in_valid1 = 1'b1;
      tick();
      in_valid1 = 1'b0;
      check("c1_not_yet", out_valid1, 0);
      tick();
      check("c1_valid", out_valid1, 1);
      check("c1_sum", s1, e1[W-1:0]);
      check("c1_co", co1, e1[W]);
      out_ready1 = 1'b1;
      tick();
      out_ready1 = 1'b0;
      check("c1_idle_ready", in_ready1, 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/lca_seq.md
# lca_seq

Multi-cycle wide-word adder sequencer. Accepts two TOTAL-bit operands plus carry-in over a valid/ready handshake and time-multiplexes one WIDTH-bit `lca` slice across CHUNKS cycles, least-significant chunk first, with the inter-chunk carry held in a register. It returns a TOTAL-bit sum and carry-out over a second valid/ready handshake. It sits between a requester and any consumer that needs a wide add but cannot afford a TOTAL-bit combinational carry chain.

## Interface
- WIDTH, 4, bit width of the `lca` slice (≥1)
- CHUNKS, 4, number of slice passes per add (≥1); TOTAL = WIDTH*CHUNKS
- clk  in  1  rising-edge clock, single clock domain
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  request carries valid operands
- in_ready  out  1  block can accept a request
- a  in  TOTAL  operand A
- b  in  TOTAL  operand B
- ci  in  1  carry-in to chunk 0
- out_valid  out  1  s/co hold a completed result
- out_ready  in  1  consumer takes the result
- s  out  TOTAL  sum, registered
- co  out  1  carry-out of the top chunk, registered
- busy  out  1  high in RUN or DONE

## Operation
- States: IDLE, RUN, DONE.
- **IDLE**
  - in_ready = 1.
  - On in_valid && in_ready: latch a, b; carry_q <= ci; idx <= 0; go to RUN.
- **RUN**
  - Slice inputs: a_q/b_q chunk [idx*WIDTH +: WIDTH], carry_q.
  - Each edge: s chunk idx <= slice sum; carry_q <= slice carry-out.
  - If idx == CHUNKS-1: co <= slice carry-out; go to DONE. Otherwise idx <= idx+1.
- **DONE**
  - out_valid = 1. s and co are stable.
  - On out_ready: go to IDLE.
  - No overlap: in_ready = 0 in RUN and DONE.
- in_valid while busy is ignored. Input changes after acceptance have no effect.
- Arithmetic is unsigned modulo 2^TOTAL; co is bit TOTAL of a + b + ci.
- idx is max(1, $clog2(CHUNKS)) bits and never exceeds CHUNKS-1.
- s keeps the last result after the out handshake; it is not cleared.
- in_ready and out_valid are registered state decodes with no combinational path from inputs.

## Timing
- Reset values: in_ready 0, out_valid 0, busy 0, s 0, co 0; state IDLE, idx 0, carry_q 0.
- in_ready rises on the first rising edge after rst_n deasserts.
- Latency: out_valid rises exactly CHUNKS edges after the accepting edge.
- Out handshake: the edge with out_valid && out_ready returns the block to IDLE; in_ready = 1 in the following cycle.
- Throughput: one add per CHUNKS+2 cycles when out_ready is held high.
- Reset asserted mid-RUN or mid-DONE clears all state and outputs immediately (asynchronous). The in-flight result is discarded and never presented.
- CHUNKS = 1: one RUN cycle; out_valid rises 1 edge after acceptance.

## Structure
- Shared package lca_pkg:
  - state enum typedef {IDLE, RUN, DONE}.
  - Default WIDTH and CHUNKS localparams.
- One sub-module: the existing `lca` slice, instantiated once with WIDTH; its ci is driven by carry_q.
- Everything else (FSM, idx counter, operand and result registers) lives in lca_seq.

## Test plan
- WIDTH=4, CHUNKS=4: a=0x1234, b=0x4321, ci=0 -> s=0x5555, co=0; out_valid exactly 4 edges after acceptance.
- a=0xFFFF, b=0x0000, ci=1 -> s=0x0000, co=1 (carry ripples through all chunks via carry_q).
- a=0x8000, b=0x8000, ci=0 with out_ready held 0 for 10 cycles:
  - out_valid stays 1; s=0x0000 and co=1 stay stable; in_ready stays 0.
  - Raise out_ready -> IDLE next edge, then in_ready=1.
- Accept a=0x0001, b=0x0001, then drive in_valid=1 with a=0xAAAA, b=0x5555 throughout RUN and DONE:
  - First result s=0x0002, co=0; second request not accepted until IDLE.
- Pulse rst_n low while idx=2 in RUN:
  - All outputs 0 asynchronously; no out_valid ever appears for that request.
  - in_ready=1 one edge after release.
- CHUNKS=1, WIDTH=4: a=0xF, b=0x1, ci=0 -> s=0x0, co=1; out_valid 1 edge after acceptance.
